// File: rtl/demux1x4_stripe_ctrl.sv
// Byte-striping scheduler for the PHY RX 1x4 demux: collects bytes round-robin into a
// 4-lane staging group and hands each committed group to the lane datapath.
module demux1x4_stripe_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int IDLE_TIMEOUT = 16,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ready_out,
   input  logic                  flush,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] data_out0,
   output logic [DATA_WIDTH-1:0] data_out1,
   output logic [DATA_WIDTH-1:0] data_out2,
   output logic [DATA_WIDTH-1:0] data_out3,
   output logic                  out_valid0,
   output logic                  out_valid1,
   output logic                  out_valid2,
   output logic                  out_valid3,
   output logic [1:0]            lane_ptr,
   output logic [CNT_WIDTH-1:0]  group_cnt
);

   localparam int IW      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int TO_LAST = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

   logic [3:0]           mask_q, mask_d;
   logic [1:0]           wr_ptr_q, wr_ptr_d;
   logic                 stage_full_q, stage_full_d;
   logic                 flush_req_q, flush_req_d;
   logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
   logic                 out_pending_q, out_pending_d;
   logic [3:0]           out_mask_q, out_mask_d;
   logic [CNT_WIDTH-1:0] group_cnt_q, group_cnt_d;

   logic       out_free;
   logic       commit;
   logic       accept;
   logic [1:0] wr_lane;
   logic [3:0][DATA_WIDTH-1:0] out_data;

   assign out_free  = !out_pending_q | out_ready;
   assign commit    = (stage_full_q | flush_req_q) & (mask_q != 4'b0000) & out_free;
   assign ready_out = !flush_req_q & (!stage_full_q | out_free);
   assign accept    = valid_in & ready_out;
   // A byte arriving with a commit opens the fresh group at lane 0.
   assign wr_lane   = commit ? 2'd0 : wr_ptr_q;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] stage_q;
         logic [DATA_WIDTH-1:0] out_q;

         always_ff @(posedge clk) begin
            if (reset) begin
               stage_q <= '0;
               out_q   <= '0;
            end else begin
               if (accept && (wr_lane == 2'(gi))) begin
                  stage_q <= data_in;
               end
               if (commit) begin
                  out_q <= stage_q;
               end
            end
         end

         assign out_data[gi] = out_q;
      end
   endgenerate

   always_comb begin
      mask_d        = mask_q;
      wr_ptr_d      = wr_ptr_q;
      flush_req_d   = flush_req_q;
      idle_cnt_d    = idle_cnt_q;
      out_pending_d = out_pending_q;
      out_mask_d    = out_mask_q;
      group_cnt_d   = group_cnt_q;

      if (commit) begin
         mask_d        = 4'b0000;
         wr_ptr_d      = 2'd0;
         flush_req_d   = 1'b0;
         out_pending_d = 1'b1;
         out_mask_d    = mask_q;
         group_cnt_d   = group_cnt_q + CNT_WIDTH'(1);
      end else if (out_ready) begin
         out_pending_d = 1'b0;
      end

      if (accept) begin
         mask_d   = mask_d | (4'b0001 << wr_lane);
         wr_ptr_d = wr_lane + 2'd1;
      end

      // Judged on the post-commit mask so a flush can never latch against an empty group.
      if (flush && (mask_d != 4'b0000)) begin
         flush_req_d = 1'b1;
      end

      if ((IDLE_TIMEOUT == 0) || accept || commit || (mask_q == 4'b0000)) begin
         idle_cnt_d = '0;
      end else if (!stage_full_q && !flush_req_q) begin
         if (idle_cnt_q == IW'(TO_LAST)) begin
            idle_cnt_d  = '0;
            flush_req_d = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
         end
      end
   end

   assign stage_full_d = (mask_d == 4'b1111);

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q        <= 4'b0000;
         wr_ptr_q      <= 2'd0;
         stage_full_q  <= 1'b0;
         flush_req_q   <= 1'b0;
         idle_cnt_q    <= '0;
         out_pending_q <= 1'b0;
         out_mask_q    <= 4'b0000;
         group_cnt_q   <= '0;
      end else begin
         mask_q        <= mask_d;
         wr_ptr_q      <= wr_ptr_d;
         stage_full_q  <= stage_full_d;
         flush_req_q   <= flush_req_d;
         idle_cnt_q    <= idle_cnt_d;
         out_pending_q <= out_pending_d;
         out_mask_q    <= out_mask_d;
         group_cnt_q   <= group_cnt_d;
      end
   end

   assign data_out0  = out_data[0];
   assign data_out1  = out_data[1];
   assign data_out2  = out_data[2];
   assign data_out3  = out_data[3];
   assign out_valid0 = out_pending_q & out_mask_q[0];
   assign out_valid1 = out_pending_q & out_mask_q[1];
   assign out_valid2 = out_pending_q & out_mask_q[2];
   assign out_valid3 = out_pending_q & out_mask_q[3];
   assign lane_ptr   = wr_ptr_q;
   assign group_cnt  = group_cnt_q;

endmodule
